// File: rtl/imm_gen_pkg.sv
// Shared immediate-format encodings, RV opcodes and the combinational immediate decoder.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    fmt_t        fmt;
    logic [63:0] imm;
  } dec_t;

  // Always produces a 64-bit result; narrower datapaths keep the low bits,
  // which is exactly sign/zero extension to that width.
  function automatic dec_t decode_imm(input logic [31:0] instr, input int xlen);
    dec_t       d;
    logic [2:0] f3;
    d.fmt = FMT_NONE;
    d.imm = '0;
    f3    = instr[14:12];
    case (instr[6:0])
      OP_LOAD, OP_JALR: begin
        d.fmt = FMT_I;
        d.imm = {{52{instr[31]}}, instr[31:20]};
      end
      OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // funct6/funct7 bits above the shift amount are masked off
          d.fmt = FMT_SHAMT;
          d.imm = (xlen == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
        end else begin
          d.fmt = FMT_I;
          d.imm = {{52{instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        d.fmt = FMT_S;
        d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        d.fmt = FMT_B;
        d.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        d.fmt = FMT_U;
        d.imm = {{32{instr[31]}}, instr[31:12], 12'd0};
      end
      OP_JAL: begin
        d.fmt = FMT_J;
        d.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen_skid.sv
// Valid/ready output register plus a one-entry skid; 1-cycle latency, FIFO order.
// in_ready is a registered flag (no combinational path from out_ready); flush empties both entries.
module imm_gen_skid #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         rdy_q;
  logic         skid_full, skid_full_nx;
  logic         out_valid_nx;
  logic [W-1:0] skid_data, skid_data_nx;
  logic [W-1:0] out_data_nx;
  logic         acc;
  logic         load_out;

  assign in_ready = rdy_q;
  assign acc      = in_valid && rdy_q;
  assign load_out = !out_valid || out_ready;

  always_comb begin
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    skid_full_nx = skid_full;
    skid_data_nx = skid_data;
    if (flush) begin
      out_valid_nx = 1'b0;
      skid_full_nx = 1'b0;
    end else if (load_out) begin
      if (skid_full) begin
        out_valid_nx = 1'b1;
        out_data_nx  = skid_data;
        skid_full_nx = acc;
        if (acc) skid_data_nx = in_data;
      end else begin
        out_valid_nx = acc;
        if (acc) out_data_nx = in_data;
      end
    end else if (acc) begin
      skid_full_nx = 1'b1;
      skid_data_nx = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_q     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else begin
      rdy_q     <= !skid_full_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      skid_full <= skid_full_nx;
      skid_data <= skid_data_nx;
    end
  end

  // Accept-with-full-skid during a drain is unreachable while in_ready tracks !skid_full.
  a_no_full_accept: assert property (@(posedge clock) disable iff (reset)
    !(acc && skid_full && out_valid && out_ready));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: 1-cycle latency, 1/cycle throughput, skid-buffered backpressure.
// Optional IMM_GEN_ILLEGAL_EN adds out_illegal and a saturating illegal_count.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
`ifdef IMM_GEN_ILLEGAL_EN
  output logic             out_illegal,
  output logic [15:0]      illegal_count,
`endif
  output logic [TAG_W-1:0] out_tag
);

  dec_t dec;
  logic unused_dec;

  assign dec        = decode_imm(in_instr, XLEN);
  assign unused_dec = ^dec.imm;

`ifdef IMM_GEN_ILLEGAL_EN
  localparam int PW = 4 + XLEN + TAG_W;
  logic illegal;
  assign illegal = (dec.fmt == FMT_NONE) || (in_instr[1:0] != 2'b11);
`else
  localparam int PW = 3 + XLEN + TAG_W;
`endif

  logic [PW-1:0] in_pay, out_pay;

`ifdef IMM_GEN_ILLEGAL_EN
  assign in_pay = {illegal, dec.fmt, dec.imm[XLEN-1:0], in_tag};
  assign {out_illegal, out_fmt, out_imm, out_tag} = out_pay;

  // Counted at accept; words dropped by a flush in the same cycle are not counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (!flush && in_valid && in_ready && illegal && illegal_count != 16'hFFFF) begin
      illegal_count <= illegal_count + 16'd1;
    end
  end
`else
  assign in_pay = {dec.fmt, dec.imm[XLEN-1:0], in_tag};
  assign {out_fmt, out_imm, out_tag} = out_pay;
`endif

  imm_gen_skid #(.W(PW)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pay)
  );

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the single-register immediate generator. Decodes the immediate and its format from a full 32-bit RV instruction word, and adds a valid/ready handshake, a one-entry skid buffer, a flush input and a sideband tag. It sits between the IF/ID register and the ID/EX register. Unlike the previous block it handles U-type formats, shift-amount masking and XLEN=32/64.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag carried alongside each instruction (typically the PC).

Ports:
clock  in  1  single clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline kill.
in_valid  in  1  instruction word present.
in_ready  out  1  block can accept this cycle.
in_instr  in  32  RV instruction word; opcode is in_instr[6:0].
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  result present.
out_ready  in  1  consumer accepts this cycle.
out_imm  out  XLEN  sign- or zero-extended immediate.
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
out_tag  out  TAG_W  tag of the instruction in out_imm.

Behaviour:
- Clock and reset: one clock `clock`; `reset` is synchronous, active-high.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_tag=0, skid buffer empty. in_ready=0 while reset is high, 1 on the first cycle after.
- Decode (combinational, ahead of the output register):
  - I format: opcodes 0000011, 0010011 (funct3 not 001/101), 1100111 -> sext(instr[31:20]).
  - SHAMT format: opcode 0010011 with funct3 001 or 101 -> zext(instr[25:20]) when XLEN=64, zext(instr[24:20]) when XLEN=32; funct6/funct7 bits are masked.
  - S format: 0100011 -> sext({instr[31:25], instr[11:7]}).
  - B format: 1100011 -> sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U format: 0110111 and 0010111 -> sext({instr[31:12], 12'b0}) to XLEN.
  - J format: 1101111 -> sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Any other opcode -> imm=0, fmt=NONE, still passed through as a valid transaction.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Latency is 1 cycle from input accept to out_valid with an empty pipe.
  - Throughput is 1 per cycle while out_ready=1.
- Skid buffer (1 entry):
  - in_ready = !skid_full; it is a registered flag with no combinational path from out_ready.
  - Accept while the output is stalled (out_valid && !out_ready) -> the decoded result goes to the skid entry.
  - When the output drains, the skid entry moves to the output register the same cycle.
  - Order is strictly FIFO. A stalled output holds out_imm, out_fmt and out_tag stable.
  - Simultaneous output drain and input accept with skid full: the skid entry goes to the output and the new input goes to the skid entry (full stays 1). This case cannot arise because in_ready=0 when the skid is full, so it is checked by assertion.
- Flush:
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An input presented in the flush cycle is dropped.
  - out_imm, out_fmt and out_tag hold their last values; they are don't-care while out_valid=0.
- Reset mid-stream: reset overrides flush and any handshake; all in-flight data is discarded.

Optional Feature:
Macro IMM_GEN_ILLEGAL_EN.
- Defined:
  - Extra output port out_illegal (1 bit), registered with the other outputs and reset to 0.
  - Asserted for fmt=NONE or when instr[1:0] != 2'b11.
  - A sticky 16-bit illegal_count output saturates at 0xFFFF and is cleared only by reset.
- Undefined: the ports are absent; NONE passes through silently.

Decomposition:
- Shared package imm_gen_pkg: fmt enum values, opcode localparams (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC), and a pure function decode_imm(instr, xlen) -> {fmt, imm}.
- One natural sub-module, imm_gen_skid: a generic valid/ready register plus a one-entry skid of parametrised payload width.

Test Plan:
- XLEN=64, in_instr=0xFFF00093 (addi -1) -> one cycle later out_imm=0xFFFFFFFFFFFFFFFF, out_fmt=1.
- in_instr=0x800002B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000, fmt=4. With XLEN=32 -> 0x80000000.
- 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFFFFFFFFFC, fmt=3. 0x4030D093 (srai 3) -> imm=3, fmt=6.
- Backpressure:
  - Stimulus: stream 4 instructions tagged 0..3 with out_ready=0 for 3 cycles.
  - Expect in_ready to drop after 2 accepts.
  - After release, tags appear 0, 1, 2, 3 in order, with no loss and no duplicates.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and presented tags never appear at the output.
- IMM_GEN_ILLEGAL_EN defined: feed 0x00000000 -> out_illegal=1 and illegal_count increments by 1. After 70000 illegal words, illegal_count=0xFFFF.
